des_sbox_seq: RTL and testbench

Parametrised, handshaked DES substitution layer. It maps a 48-bit post-expansion/key-mix word to the 32-bit S-box output by evaluating all eight standard DES S-boxes S1..S8 (FIPS 46-3). Throughput is traded against area: `LANES` S-boxes are evaluated per cycle over `8/LANES` cycles. It sits in the round function between the key-XOR stage and the P permutation, and replaces per-S-box instantiation with a single sequenced unit.

---
 rtl/des_sbox_seq.sv | 135 +++++++++++++
 tb/tb_des_sbox_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_sbox_seq.sv
// des_sbox_seq: sequenced DES substitution layer (S1..S8).
// Evaluates LANES S-boxes per cycle over STEPS = 8/LANES cycles, mapping a
// 48-bit key-mixed word to the 32-bit S-box output.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_data[47:42] feeds S1 ... [5:0] S8
//   out_valid/out_ready   output handshake; out_data[31:28] from S1 ... [3:0] S8
//   busy                  high whenever the FSM is not idle
module des_sbox_seq #(
    parameter int unsigned LANES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int unsigned STEPS  = 8 / LANES;
    localparam int unsigned CW     = $clog2(STEPS) + 1;
    localparam int unsigned LW     = 4 * LANES;
    localparam int unsigned SR_SH  = 6 * LANES;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("des_sbox_seq: LANES must be 1, 2, 4 or 8");
    end

    // S-box tables: 64 nibbles each, entry (row*16 + col) at the MSB end first.
    localparam logic [255:0] SBOX1 = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
    localparam logic [255:0] SBOX2 = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
    localparam logic [255:0] SBOX3 = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
    localparam logic [255:0] SBOX4 = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
    localparam logic [255:0] SBOX5 = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
    localparam logic [255:0] SBOX6 = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
    localparam logic [255:0] SBOX7 = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
    localparam logic [255:0] SBOX8 = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [47:0]     sr;
    logic [31:0]     acc;
    logic [CW-1:0]   cnt;
    logic [LW-1:0]   lane_res;
    logic [31:0]     acc_next;
    logic [47:0]     sr_next;

    // Look up one 6-bit chunk in S-box idx (0 = S1); row = {b5,b0}, col = b[4:1].
    function automatic logic [3:0] sbox_lookup(input logic [2:0] idx, input logic [5:0] b);
        logic [255:0] t;
        logic [5:0]   addr;
        int unsigned  pos;
        case (idx)
            3'd0:    t = SBOX1;
            3'd1:    t = SBOX2;
            3'd2:    t = SBOX3;
            3'd3:    t = SBOX4;
            3'd4:    t = SBOX5;
            3'd5:    t = SBOX6;
            3'd6:    t = SBOX7;
            default: t = SBOX8;
        endcase
        addr = {b[5], b[0], b[4:1]};
        pos  = 252 - 4 * 32'(addr);
        return t[pos +: 4];
    endfunction

    // Lane evaluation for the current step; lane 0 lands most significant.
    always_comb begin
        lane_res = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_res[LW - 4 - 4*i +: 4] = sbox_lookup(3'(32'(cnt) * LANES + i), sr[47 - 6*i -: 6]);
        end
        acc_next = (acc << LW) | 32'(lane_res);
        sr_next  = sr << SR_SH;
    end

    // Control FSM with datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr    <= in_data;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sr  <= sr_next;
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(STEPS - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_data  <= acc_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // Handoff and next accept share this edge.
                        if (in_valid) begin
                            sr    <= in_data;
                            cnt   <= '0;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_des_sbox_seq.sv
// Directed bench for des_sbox_seq; one instance per legal LANES value
// (index k -> LANES = 1<<k, STEPS = 8>>k).
module tb_des_sbox_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [4];
    logic        in_ready  [4];
    logic [47:0] in_data   [4];
    logic        out_valid [4];
    logic        out_ready [4];
    logic [31:0] out_data  [4];
    logic        busy      [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        des_sbox_seq #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .busy      (busy[g])
        );
    end

    // Stimulus only: accept one word on instance k, wait (bounded) for out_valid.
    task automatic send_word(input int k, input logic [47:0] d, output int cyc, output logic [31:0] got);
        @(negedge clk);
        in_data[k]  = d;
        in_valid[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        cyc = 0;
        while (!out_valid[k] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        got = out_data[k];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (out_valid[k] !== 1'b0) begin bad++; $display("FAIL reset_out_valid lanes=%0d got=%b exp=0", 1 << k, out_valid[k]); end
            total++;
            if (busy[k] !== 1'b0) begin bad++; $display("FAIL reset_busy lanes=%0d got=%b exp=0", 1 << k, busy[k]); end
            total++;
            if (out_data[k] !== 32'h0) begin bad++; $display("FAIL reset_out_data lanes=%0d got=%h exp=00000000", 1 << k, out_data[k]); end
            total++;
            if (in_ready[k] !== 1'b1) begin bad++; $display("FAIL reset_in_ready lanes=%0d got=%b exp=1", 1 << k, in_ready[k]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_all_zero();
        int cyc;
        logic [31:0] got;
        for (int k = 0; k < 4; k++) begin
            send_word(k, 48'h000000000000, cyc, got);
            total++;
            if (cyc !== (8 >> k)) begin bad++; $display("FAIL zero_latency lanes=%0d got=%0d exp=%0d", 1 << k, cyc, 8 >> k); end
            total++;
            if (got !== 32'hEFA72C4D) begin bad++; $display("FAIL zero_data lanes=%0d got=%h exp=EFA72C4D", 1 << k, got); end
        end
    endtask

    task automatic test_all_ones();
        int cyc;
        logic [31:0] got;
        for (int k = 0; k < 4; k++) begin
            send_word(k, 48'hFFFFFFFFFFFF, cyc, got);
            total++;
            if (cyc !== (8 >> k)) begin bad++; $display("FAIL ones_latency lanes=%0d got=%0d exp=%0d", 1 << k, cyc, 8 >> k); end
            total++;
            if (got !== 32'hD9CE3DCB) begin bad++; $display("FAIL ones_data lanes=%0d got=%h exp=D9CE3DCB", 1 << k, got); end
        end
    endtask

    task automatic test_round_vector();
        int cyc;
        logic [31:0] got;
        for (int k = 0; k < 4; k++) begin
            send_word(k, 48'h6117BA866527, cyc, got);
            total++;
            if (got !== 32'h5C82B597) begin bad++; $display("FAIL round_data lanes=%0d got=%h exp=5C82B597", 1 << k, got); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [31:0] got;
        out_ready[1] = 1'b0;
        send_word(1, 48'h6117BA866527, cyc, got);
        total++;
        if (cyc !== 4) begin bad++; $display("FAIL bp_latency got=%0d exp=4", cyc); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid[1] !== 1'b1 || busy[1] !== 1'b1 || in_ready[1] !== 1'b0 || out_data[1] !== 32'h5C82B597) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d got v=%b busy=%b rdy=%b data=%h exp v=1 busy=1 rdy=0 data=5C82B597",
                         i, out_valid[1], busy[1], in_ready[1], out_data[1]);
            end
        end
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        in_data[1]   = 48'h000000000000;
        #1;
        total++;
        if (in_ready[1] !== 1'b1) begin bad++; $display("FAIL bp_ready_comb got=%b exp=1", in_ready[1]); end
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        total++;
        if (out_valid[1] !== 1'b0 || busy[1] !== 1'b1 || in_ready[1] !== 1'b0) begin
            bad++;
            $display("FAIL bp_handoff got v=%b busy=%b rdy=%b exp v=0 busy=1 rdy=0", out_valid[1], busy[1], in_ready[1]);
        end
        cyc = 0;
        while (!out_valid[1] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== 4) begin bad++; $display("FAIL b2b_latency got=%0d exp=4", cyc); end
        total++;
        if (out_data[1] !== 32'hEFA72C4D) begin bad++; $display("FAIL b2b_data got=%h exp=EFA72C4D", out_data[1]); end
        @(negedge clk);
        total++;
        if (out_valid[1] !== 1'b0 || busy[1] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain got v=%b busy=%b exp v=0 busy=0", out_valid[1], busy[1]);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        logic [31:0] got;
        @(negedge clk);
        in_data[0]  = 48'hFFFFFFFFFFFF;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #2;
        total++;
        if (busy[0] !== 1'b1) begin bad++; $display("FAIL midrun_busy_before got=%b exp=1", busy[0]); end
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || out_data[0] !== 32'h0 || in_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL midrun_reset got v=%b busy=%b data=%h rdy=%b exp v=0 busy=0 data=00000000 rdy=1",
                     out_valid[0], busy[0], out_data[0], in_ready[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_word(0, 48'h6117BA866527, cyc, got);
        total++;
        if (cyc !== 8) begin bad++; $display("FAIL midrun_latency got=%0d exp=8", cyc); end
        total++;
        if (got !== 32'h5C82B597) begin bad++; $display("FAIL midrun_data got=%h exp=5C82B597", got); end
    endtask

    task automatic test_run_ignore();
        int cyc;
        logic extra;
        @(negedge clk);
        in_data[1]  = 48'hFFFFFFFFFFFF;
        in_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data[1] = 48'h000000000000;
        total++;
        if (in_ready[1] !== 1'b0) begin bad++; $display("FAIL run_in_ready got=%b exp=0", in_ready[1]); end
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        cyc = 1;
        while (!out_valid[1] && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc !== 4) begin bad++; $display("FAIL run_ignore_latency got=%0d exp=4", cyc); end
        total++;
        if (out_data[1] !== 32'hD9CE3DCB) begin bad++; $display("FAIL run_ignore_data got=%h exp=D9CE3DCB", out_data[1]); end
        extra = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid[1] !== 1'b0 || busy[1] !== 1'b0) extra = 1'b1;
        end
        total++;
        if (extra !== 1'b0) begin bad++; $display("FAIL run_ignore_extra got=%b exp=0", extra); end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b1;
        end
        test_reset();
        test_all_zero();
        test_all_ones();
        test_round_vector();
        test_back_to_back();
        test_reset_mid_run();
        test_run_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
